// File: rtl/countdown_capture.sv
// Photo-booth countdown: 3-2-1 bar overlay, white flash, one-cycle capture pulse, then review.
// Optional macro CAPTURE_RETRY_EN lets btnc_pressed in REVIEW restart the countdown for a retake.
module countdown_capture #(
  parameter int          FRAMES_PER_SEC = 60,
  parameter int          COUNT_SECS     = 3,
  parameter int          FLASH_FRAMES   = 6,
  parameter int          BOX_X          = 32,
  parameter int          BOX_Y          = 32,
  parameter int          BAR_W          = 16,
  parameter int          BAR_H          = 64,
  parameter logic [11:0] BAR_COLOR      = 12'hF00
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        btnc_pressed,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [11:0] cam_pixel_in,
  output logic [11:0] pixel_out,
  output logic        capture_out,
  output logic [2:0]  count_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FLASH     = 3'd2,
    S_CAPTURE   = 3'd3,
    S_REVIEW    = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        start_q;
  logic [2:0]  count, count_n;
  logic [7:0]  frame_cnt, frame_n;
  logic [7:0]  flash_cnt, flash_n;
  logic [11:0] pixel_n;
  logic        tick;
  logic        start_edge;
  logic        in_bar_x;
  logic        in_bar_y;

  assign tick       = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign start_edge = start_in && !start_q;
  assign state_dbg  = state;
  assign count_out  = count;

`ifndef CAPTURE_RETRY_EN
  // REVIEW is terminal in this build, so the button is intentionally left unused.
  logic unused_btnc;
  assign unused_btnc = btnc_pressed;
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    frame_n = frame_cnt;
    flash_n = flash_cnt;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_n = S_COUNTDOWN;
          count_n = 3'(COUNT_SECS);
          frame_n = 8'd0;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (frame_cnt == 8'(FRAMES_PER_SEC - 1)) begin
            frame_n = 8'd0;
            if (count == 3'd1) begin
              state_n = S_FLASH;
              flash_n = 8'd0;
              count_n = 3'd0;
            end else begin
              count_n = count - 3'd1;
            end
          end else begin
            frame_n = frame_cnt + 8'd1;
          end
        end
      end
      S_FLASH: begin
        if (tick) begin
          if (flash_cnt == 8'(FLASH_FRAMES - 1)) begin
            state_n = S_CAPTURE;
            flash_n = 8'd0;
          end else begin
            flash_n = flash_cnt + 8'd1;
          end
        end
      end
      S_CAPTURE: state_n = S_REVIEW;
      S_REVIEW: begin
`ifdef CAPTURE_RETRY_EN
        if (btnc_pressed) begin
          state_n = S_COUNTDOWN;
          count_n = 3'(COUNT_SECS);
          frame_n = 8'd0;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bar i occupies [BOX_X + 2*i*BAR_W, BOX_X + 2*i*BAR_W + BAR_W); only bars below count are lit.
  always_comb begin
    in_bar_x = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if ((3'(i) < count) &&
          (hcount_in >= 11'(BOX_X + 2 * i * BAR_W)) &&
          (hcount_in <  11'(BOX_X + 2 * i * BAR_W + BAR_W)))
        in_bar_x = 1'b1;
    end
  end

  assign in_bar_y = (vcount_in >= 10'(BOX_Y)) && (vcount_in < 10'(BOX_Y + BAR_H));

  always_comb begin
    pixel_n = cam_pixel_in;
    case (state)
      S_COUNTDOWN: if (in_bar_x && in_bar_y) pixel_n = BAR_COLOR;
      S_FLASH,
      S_CAPTURE:   pixel_n = 12'hFFF;
      default:     pixel_n = cam_pixel_in;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      start_q     <= 1'b1;
      count       <= 3'd0;
      frame_cnt   <= 8'd0;
      flash_cnt   <= 8'd0;
      pixel_out   <= 12'd0;
      capture_out <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      state       <= state_n;
      start_q     <= start_in;
      count       <= count_n;
      frame_cnt   <= frame_n;
      flash_cnt   <= flash_n;
      pixel_out   <= pixel_n;
      capture_out <= (state_n == S_CAPTURE);
      busy_out    <= (state_n == S_COUNTDOWN) || (state_n == S_FLASH) || (state_n == S_CAPTURE);
      done_out    <= (state_n == S_REVIEW);
    end
  end

endmodule

// File: tb/tb_countdown_capture.sv
// Directed bench for countdown_capture on a short 16x8 frame (2 ticks per step, 3 steps, 2 flash ticks).
module tb_countdown_capture;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        btnc_pressed;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [11:0] cam_pixel_in;
  logic [11:0] pixel_out;
  logic        capture_out;
  logic [2:0]  count_out;
  logic        busy_out;
  logic        done_out;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int ticks  = 0;
  bit busy_bad = 1'b0;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_REVIEW    = 3'd4;

  countdown_capture #(
    .FRAMES_PER_SEC(2),
    .COUNT_SECS    (3),
    .FLASH_FRAMES  (2)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .btnc_pressed(btnc_pressed),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .cam_pixel_in(cam_pixel_in),
    .pixel_out   (pixel_out),
    .capture_out (capture_out),
    .count_out   (count_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .state_dbg   (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the short raster by one pixel; ticks counts frame-origin cycles handed to the DUT.
  task automatic adv();
    if (hcount_in == 11'd15) begin
      hcount_in = 11'd0;
      vcount_in = (vcount_in == 10'd7) ? 10'd0 : vcount_in + 10'd1;
    end else begin
      hcount_in = hcount_in + 11'd1;
    end
    if (hcount_in == 11'd0 && vcount_in == 10'd0) ticks++;
  endtask

  // Runs the raster until count_out leaves 'from'; ok=0 if the cycle budget expires.
  task automatic wait_count_change(input logic [2:0] from, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      adv();
      @(negedge clk_in);
      if (busy_out !== 1'b1) busy_bad = 1'b1;
      if (count_out !== from) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b1; btnc_pressed = 1'b0;
    hcount_in = 11'd5; vcount_in = 10'd3; cam_pixel_in = 12'h3C3;
    repeat (3) @(negedge clk_in);
    checks++; if (pixel_out !== 12'd0) begin errors++; $display("FAIL reset_pixel: got %h want 000", pixel_out); end
    checks++; if (capture_out !== 1'b0) begin errors++; $display("FAIL reset_capture: got %b want 0", capture_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_out); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst_in = 1'b0;
    // start_in stays high across release: must not launch.
    for (int n = 0; n < 40; n++) begin
      adv();
      @(negedge clk_in);
    end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL held_start_busy: got %b want 0", busy_out); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL held_start_state: got %0d want 0", state_dbg); end
    checks++; if (pixel_out !== 12'h3C3) begin errors++; $display("FAIL idle_pixel: got %h want 3C3", pixel_out); end
    start_in = 1'b0;
    adv();
    @(negedge clk_in);
  endtask

  task automatic test_launch();
    bit ok;
    start_in = 1'b1;
    adv();
    @(negedge clk_in);
    checks++; if (count_out !== 3'd3) begin errors++; $display("FAIL launch_count: got %0d want 3", count_out); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL launch_busy: got %b want 1", busy_out); end
    ticks = 0;
    wait_count_change(3'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL step3_timeout: got no change want count 2"); end
    checks++; if (count_out !== 3'd2) begin errors++; $display("FAIL step3_count: got %0d want 2", count_out); end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL step3_ticks: got %0d want 2", ticks); end
    ticks = 0;
  endtask

  task automatic test_overlay();
    logic [10:0] save_h;
    logic [9:0]  save_v;
    logic [10:0] hx [10] = '{11'd32, 11'd47, 11'd48, 11'd64, 11'd79, 11'd80, 11'd96, 11'd32, 11'd31, 11'd32};
    logic [9:0]  vy [10] = '{10'd32, 10'd32, 10'd32, 10'd32, 10'd95, 10'd32, 10'd32, 10'd96, 10'd32, 10'd31};
    logic [11:0] ex [10] = '{12'hF00, 12'hF00, 12'h0A5, 12'hF00, 12'hF00,
                             12'h0A5, 12'h0A5, 12'h0A5, 12'h0A5, 12'h0A5};
    save_h = hcount_in;
    save_v = vcount_in;
    cam_pixel_in = 12'h0A5;
    for (int k = 0; k < 10; k++) begin
      hcount_in = hx[k];
      vcount_in = vy[k];
      @(negedge clk_in);
      checks++;
      if (pixel_out !== ex[k]) begin
        errors++;
        $display("FAIL overlay_%0d (x=%0d y=%0d): got %h want %h", k, hx[k], vy[k], pixel_out, ex[k]);
      end
    end
    checks++; if (count_out !== 3'd2) begin errors++; $display("FAIL overlay_count_hold: got %0d want 2", count_out); end
    hcount_in = save_h;
    vcount_in = save_v;
  endtask

  task automatic test_btnc_countdown();
    bit ok;
    btnc_pressed = 1'b1;
    adv();
    @(negedge clk_in);
    btnc_pressed = 1'b0;
    checks++; if (count_out !== 3'd2) begin errors++; $display("FAIL btnc_countdown_count: got %0d want 2", count_out); end
    wait_count_change(3'd2, ok);
    checks++; if (!ok || count_out !== 3'd1) begin errors++; $display("FAIL step2_count: got %0d want 1", count_out); end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL step2_ticks: got %0d want 2", ticks); end
    ticks = 0;
    wait_count_change(3'd1, ok);
    checks++; if (!ok || count_out !== 3'd0) begin errors++; $display("FAIL step1_count: got %0d want 0", count_out); end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL step1_ticks: got %0d want 2", ticks); end
    checks++; if (busy_bad) begin errors++; $display("FAIL countdown_busy: got busy low want 1 throughout"); end
  endtask

  task automatic test_flash_capture();
    bit ok = 1'b0;
    bit flash_bad = 1'b0;
    ticks = 0;
    cam_pixel_in = 12'h123;
    for (int n = 0; n < 600; n++) begin
      adv();
      @(negedge clk_in);
      if (capture_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (pixel_out !== 12'hFFF || busy_out !== 1'b1) flash_bad = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL capture_timeout: got no capture pulse want 1"); end
    checks++; if (flash_bad) begin errors++; $display("FAIL flash_pixel: got non-white or idle want FFF busy"); end
    checks++; if (ticks !== 2) begin errors++; $display("FAIL flash_ticks: got %0d want 2", ticks); end
    checks++; if (pixel_out !== 12'hFFF) begin errors++; $display("FAIL capture_pixel: got %h want FFF", pixel_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL capture_done: got %b want 0", done_out); end
    adv();
    @(negedge clk_in);
    checks++; if (capture_out !== 1'b0) begin errors++; $display("FAIL capture_width: got %b want 0", capture_out); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL review_done: got %b want 1", done_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL review_busy: got %b want 0", busy_out); end
  endtask

  task automatic test_review();
    logic [11:0] cams [4] = '{12'h0A5, 12'h5A0, 12'hABC, 12'h001};
    for (int k = 0; k < 4; k++) begin
      cam_pixel_in = cams[k];
      adv();
      @(negedge clk_in);
      checks++;
      if (pixel_out !== cams[k]) begin
        errors++;
        $display("FAIL review_pixel_%0d: got %h want %h", k, pixel_out, cams[k]);
      end
    end
    for (int n = 0; n < 300; n++) begin
      adv();
      @(negedge clk_in);
    end
    checks++; if (state_dbg !== ST_REVIEW || done_out !== 1'b1) begin
      errors++; $display("FAIL review_hold: got state %0d done %b want 4 1", state_dbg, done_out);
    end
  endtask

  task automatic test_review_btnc();
    btnc_pressed = 1'b1;
    adv();
    @(negedge clk_in);
    btnc_pressed = 1'b0;
`ifdef CAPTURE_RETRY_EN
    checks++; if (count_out !== 3'd3) begin errors++; $display("FAIL retry_count: got %0d want 3", count_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL retry_done: got %b want 0", done_out); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL retry_busy: got %b want 1", busy_out); end
`else
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL noretry_count: got %0d want 0", count_out); end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL noretry_done: got %b want 1", done_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL noretry_busy: got %b want 0", busy_out); end
`endif
  endtask

  task automatic test_async_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    start_in = 1'b0;
    adv();
    @(negedge clk_in);
    start_in = 1'b1;
    cam_pixel_in = 12'h0A5;
    adv();
    @(negedge clk_in);
    for (int n = 0; n < 20; n++) begin
      adv();
      @(negedge clk_in);
    end
    checks++; if (state_dbg !== ST_COUNTDOWN || count_out !== 3'd3) begin
      errors++; $display("FAIL prereset_state: got state %0d count %0d want 1 3", state_dbg, count_out);
    end
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL async_state: got %0d want 0", state_dbg); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL async_count: got %0d want 0", count_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy_out); end
    checks++; if (pixel_out !== 12'd0) begin errors++; $display("FAIL async_pixel: got %h want 000", pixel_out); end
    checks++; if (capture_out !== 1'b0 || done_out !== 1'b0) begin
      errors++; $display("FAIL async_flags: got cap %b done %b want 0 0", capture_out, done_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_launch();
    test_overlay();
    test_btnc_countdown();
    test_flash_capture();
    test_review();
    test_review_btnc();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
